// File: rtl/mcu_int_pkg.sv
// ============================================================================
// mcu_int_pkg : shared FSM state, source codes and vector defaults for the
//               interrupt controller and dispatch stage.   Rev 1.0
// ============================================================================
`default_nettype none

package mcu_int_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SAVE    = 3'd1,
      ST_VECTOR  = 3'd2,
      ST_SERVICE = 3'd3,
      ST_RESTORE = 3'd4
   } disp_state_t;

   localparam logic [1:0]  SRC_INT0 = 2'b10;
   localparam logic [1:0]  SRC_INT1 = 2'b01;
   localparam logic [1:0]  SRC_NONE = 2'b00;

   localparam logic [15:0] VEC0_DEF = 16'h0003;
   localparam logic [15:0] VEC1_DEF = 16'h0013;

   // Ordering none < INT1 < INT0; the illegal code 11 ranks as INT0.
   function automatic logic [1:0] src_prio(input logic [1:0] src);
      logic [1:0] p;
      p = 2'd0;
      if (src[1])      p = 2'd2;
      else if (src[0]) p = 2'd1;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/int_ret_stack.sv
// ============================================================================
// int_ret_stack : small LIFO holding saved return PCs.   Rev 1.0
// ============================================================================
`default_nettype none

module int_ret_stack #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    w_top_idx;

   assign w_top_idx = r_cnt - CW'(1);
   assign empty     = (r_cnt == '0);
   assign full      = (r_cnt == CW'(DEPTH));
   assign top       = empty ? '0 : r_mem[w_top_idx[IW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (push && !full) begin
         r_mem[r_cnt[IW-1:0]] <= din;
         r_cnt                <= r_cnt + CW'(1);
      end else if (pop && !empty) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/int_dispatch.sv
// ============================================================================
// int_dispatch : CPU-side interrupt entry/return sequencer.   Rev 1.0
// Build option: INT_NEST_EN allows INT0 to preempt an INT1 handler.
// ============================================================================
`default_nettype none

module int_dispatch
   import mcu_int_pkg::*;
#(
   parameter int              PC_W = 16,
   parameter logic [PC_W-1:0] VEC0 = VEC0_DEF,
   parameter logic [PC_W-1:0] VEC1 = VEC1_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      int_req,
   input  logic            instr_done,
   input  logic            reti,
   input  logic [PC_W-1:0] pc_in,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_out,
   output logic [1:0]      clr_en,
   output logic [1:0]      in_service,
   output logic            err
);

`ifdef INT_NEST_EN
   localparam int STACK_DEPTH = 2;
`else
   localparam int STACK_DEPTH = 1;
`endif

   disp_state_t     r_state, w_next;
   logic [1:0]      r_src;
   logic [PC_W-1:0] r_ret_pc;
   logic [1:0]      r_in_service;
   logic            r_err;

   logic [1:0]      w_src;
   logic [1:0]      w_level;
   logic            w_elig;
   logic            w_accept;
   logic [1:0]      w_is_after;
   logic            w_push, w_pop;
   logic [PC_W-1:0] w_top;
   logic            w_stk_empty, w_stk_full;

   assign w_src   = int_req[1] ? SRC_INT0 : (int_req[0] ? SRC_INT1 : SRC_NONE);
   assign w_level = r_in_service[1] ? SRC_INT0 : (r_in_service[0] ? SRC_INT1 : SRC_NONE);

`ifdef INT_NEST_EN
   assign w_elig = (w_src != SRC_NONE) && (src_prio(w_src) > src_prio(w_level));
`else
   assign w_elig = (w_src != SRC_NONE) && (r_in_service == 2'b00);
`endif

   assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_SERVICE)) &&
                       instr_done && !reti && w_elig;
   // Return always unwinds the highest-priority active handler first.
   assign w_is_after = r_in_service[1] ? (r_in_service & 2'b01) : 2'b00;

   assign in_service = r_in_service;
   assign err        = r_err;

   int_ret_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_W)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   (r_ret_pc),
      .top   (w_top),
      .empty (w_stk_empty),
      .full  (w_stk_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_src        <= SRC_NONE;
         r_ret_pc     <= '0;
         r_in_service <= 2'b00;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_src    <= w_src;
            r_ret_pc <= pc_in;
         end
         if (r_state == ST_SAVE)
            r_in_service <= r_in_service | r_src;
         else if (r_state == ST_RESTORE)
            r_in_service <= w_is_after;
         if ((r_state == ST_IDLE) && reti)
            r_err <= 1'b1;
      end
   end

   always_comb begin
      w_next  = r_state;
      pc_load = 1'b0;
      pc_out  = '0;
      clr_en  = 2'b00;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_SAVE;
         end
         ST_SERVICE: begin
            if (reti)          w_next = ST_RESTORE;
            else if (w_accept) w_next = ST_SAVE;
         end
         ST_SAVE: begin
            w_push = !w_stk_full;
            clr_en = r_src;
            w_next = ST_VECTOR;
         end
         ST_VECTOR: begin
            pc_load = 1'b1;
            pc_out  = (r_src == SRC_INT0) ? VEC0 : VEC1;
            w_next  = ST_SERVICE;
         end
         ST_RESTORE: begin
            w_pop   = !w_stk_empty;
            pc_load = 1'b1;
            pc_out  = w_top;
            w_next  = (w_is_after != 2'b00) ? ST_SERVICE : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire

// File: doc/int_dispatch.md
Name: int_dispatch

Overview:
- Downstream stage of the two-source interrupt controller.
- Consumes the controller's 2-bit service code (2'b10 = INT0, 2'b01 = INT1, 2'b00 = none) and performs CPU-side entry: saves the return PC, redirects the PC to the source vector, and pulses the source's enable-clear so the controller leaves its service state.
- On RETI it restores the saved PC and tracks nesting depth.
- Sits between the interrupt controller and the PC/fetch unit.

Parameters:
- PC_W, 16, program counter width.
- VEC0, 16'h0003, INT0 vector address.
- VEC1, 16'h0013, INT1 vector address.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- int_req  input  2  service code from the interrupt controller (10 = INT0, 01 = INT1).
- instr_done  input  1  current instruction completes this cycle; the only point an interrupt may be taken.
- reti  input  1  RETI retiring this cycle; single-cycle pulse.
- pc_in  input  PC_W  address of the next sequential instruction (return address).
- pc_load  output  1  one-cycle strobe; fetch unit loads pc_out.
- pc_out  output  PC_W  vector or restored return address; valid while pc_load=1, else 0.
- clr_en  output  2  one-cycle pulse clearing the source enable bit ([1] = INT0, [0] = INT1).
- in_service  output  2  sources currently being serviced, same bit order.
- err  output  1  sticky; set on RETI with nothing in service.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, stack empty, pc_load=0, pc_out=0, clr_en=0, in_service=0, err=0. Reset mid-sequence abandons it; nothing is restored.
- FSM states: IDLE, SAVE, VECTOR, SERVICE, RESTORE.
- Request decode:
  - 2'b11 is treated as INT0.
  - A request is eligible only if its priority is above the current level: none < INT1 < INT0.
  - A request for a source already in service is ignored.
- Entry from IDLE or SERVICE:
  - Condition: instr_done=1, eligible request, and reti=0.
  - Next state SAVE; latch the source.
- SAVE (1 cycle):
  - Push the pc_in value captured at the instr_done cycle.
  - clr_en pulse for the latched source.
  - Set that source's in_service bit.
- VECTOR (1 cycle): pc_load=1, pc_out=VEC0 or VEC1. Next state SERVICE.
- Entry latency: instr_done at cycle N gives clr_en at N+1 and pc_load at N+2.
- SERVICE:
  - reti=1 goes to RESTORE. reti has priority over a simultaneous request; the request is re-evaluated at the next instr_done.
- RESTORE (1 cycle):
  - Pop the stack; pc_load=1, pc_out = popped PC.
  - Clear the highest-priority set in_service bit.
  - Next state SERVICE if the stack is still non-empty, else IDLE.
- reti in IDLE: err<=1, no other effect. err clears only on reset.
- instr_done and reti are ignored in SAVE, VECTOR and RESTORE.
- Stack:
  - Depth 2. Overflow is impossible by the priority rule.
  - Push and pop never occur in the same cycle.
- int_req is sampled only at instr_done. Deassertion after acceptance does not abort entry.

Optional Feature:
- Macro: INT_NEST_EN.
- Defined: INT0 may preempt an INT1 handler (nesting, stack depth 2) as described above.
- Undefined:
  - No request is accepted while in_service != 0; the stack is depth 1.
  - A pending INT0 during an INT1 handler is taken at the first instr_done after returning to IDLE.

Decomposition:
- Package mcu_int_pkg:
  - FSM state enum.
  - Source code constants SRC_INT0=2'b10, SRC_INT1=2'b01, SRC_NONE=2'b00.
  - Default vector constants.
  - Shared with the interrupt controller.
- Sub-module int_ret_stack:
  - Parameterised depth/width LIFO with push, pop, empty, full and top outputs.
  - Holds the saved PCs.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then int_req=00 with instr_done toggling -> all outputs 0, no pc_load.
- Single INT0: pc_in=16'h0120, int_req=10, instr_done at N -> clr_en=10 at N+1; pc_load=1 with pc_out=16'h0003 at N+2; in_service=10. Then reti -> pc_load=1 with pc_out=16'h0120 next cycle; in_service=00; state IDLE.
- Nesting (INT_NEST_EN):
  - INT1 taken at pc_in=16'h0200 -> pc_out=16'h0013.
  - INT0 then taken at pc_in=16'h0015 -> pc_out=16'h0003, in_service=11.
  - First reti -> pc_out=16'h0015, in_service=01.
  - Second reti -> pc_out=16'h0200, in_service=00.
- Same/lower priority blocked: during an INT0 handler, int_req=01 with instr_done -> no clr_en, no pc_load. After reti, the next instr_done takes INT1.
- Simultaneous events: in SERVICE with INT1 active, reti=1 and int_req=10 with instr_done in the same cycle -> RESTORE first. INT0 is taken at the next instr_done.
- Error and illegal code: reti in IDLE -> err=1, sticky until reset. int_req=11 -> dispatches INT0 with pc_out=16'h0003 and clr_en=10.
